// File: rtl/round_timer.sv
// Two-digit BCD countdown timer driven by an upstream tick counter.
// Load captures a clamped start value; start runs it; expiry pulses once at 00.
module round_timer #(
    parameter int AUTO_RELOAD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] start_tens,
    input  logic [3:0] start_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic       count_en,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       expired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic [3:0] r_rel_tens;
    logic [3:0] r_rel_ones;
    logic       r_count_en;
    logic       r_running;
    logic       r_expired;

    logic [3:0] w_cap_tens;
    logic [3:0] w_cap_ones;
    logic [3:0] w_dec_tens;
    logic [3:0] w_dec_ones;
    logic       w_tick_ok;
    logic       w_at_one;
    logic       w_at_zero;

    assign w_cap_tens = (start_tens > 4'd9) ? 4'd9 : start_tens;
    assign w_cap_ones = (start_ones > 4'd9) ? 4'd9 : start_ones;
    assign w_at_one   = (r_tens == 4'd0) && (r_ones == 4'd1);
    assign w_at_zero  = (r_tens == 4'd0) && (r_ones == 4'd0);

    // A tick only counts once the registered enable has caught up, and never
    // in the cycle right after an expiry so pulses cannot sit back to back.
    assign w_tick_ok  = tick && !pause && r_count_en && !r_expired;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_dec_tens = r_tens;
        w_dec_ones = r_ones;
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
        end else if (r_tens != 4'd0) begin
            w_dec_ones = 4'd9;
            w_dec_tens = r_tens - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_rel_tens <= 4'd0;
            r_rel_ones <= 4'd0;
            r_count_en <= 1'b0;
            r_running  <= 1'b0;
            r_expired  <= 1'b0;
        end else begin
            r_expired  <= 1'b0;
            r_count_en <= (r_state == S_RUN) && !pause;

            if (load) begin
                r_tens     <= w_cap_tens;
                r_ones     <= w_cap_ones;
                r_rel_tens <= w_cap_tens;
                r_rel_ones <= w_cap_ones;
                r_state    <= S_ARMED;
                r_running  <= 1'b0;
            end else begin
                case (r_state)
                    S_ARMED: begin
                        if (start) begin
                            if (w_at_zero) begin
                                r_state   <= S_DONE;
                                r_expired <= 1'b1;
                            end else begin
                                r_state   <= S_RUN;
                                r_running <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_tick_ok) begin
                            if (w_at_one) begin
                                r_expired <= 1'b1;
                                if (AUTO_RELOAD != 0) begin
                                    r_tens <= r_rel_tens;
                                    r_ones <= r_rel_ones;
                                end else begin
                                    r_tens    <= 4'd0;
                                    r_ones    <= 4'd0;
                                    r_state   <= S_DONE;
                                    r_running <= 1'b0;
                                end
                            end else if (!w_at_zero) begin
                                r_tens <= w_dec_tens;
                                r_ones <= w_dec_ones;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign count_en = r_count_en;
    assign tens     = r_tens;
    assign ones     = r_ones;
    assign running  = r_running;
    assign expired  = r_expired;

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer: a vector table plus multi-cycle sequences,
// with one instance of each AUTO_RELOAD setting fed the same stimulus.
module tb_round_timer;

    logic       clk = 1'b0;
    logic       rst, load, start, pause, tick;
    logic [3:0] start_tens, start_ones;

    logic       ce0, run0, exp0, ce1, run1, exp1;
    logic [3:0] t0, o0, t1, o1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    round_timer #(.AUTO_RELOAD(0)) dut (
        .clk(clk), .rst(rst), .load(load), .start_tens(start_tens),
        .start_ones(start_ones), .start(start), .pause(pause), .tick(tick),
        .count_en(ce0), .tens(t0), .ones(o0), .running(run0), .expired(exp0)
    );

    round_timer #(.AUTO_RELOAD(1)) dut_ar (
        .clk(clk), .rst(rst), .load(load), .start_tens(start_tens),
        .start_ones(start_ones), .start(start), .pause(pause), .tick(tick),
        .count_en(ce1), .tens(t1), .ones(o1), .running(run1), .expired(exp1)
    );

    typedef struct {
        logic       load;
        logic [3:0] st;
        logic [3:0] so;
        logic       start;
        logic       pause;
        logic       tick;
        logic [7:0] e_digits;
        logic       e_run;
        logic       e_exp;
        logic       e_ce;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; pause = 0; tick = 0; start_tens = 0; start_ones = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    task automatic do_load(input logic [3:0] tt, input logic [3:0] oo);
        load = 1; start_tens = tt; start_ones = oo;
        cyc();
        load = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        cyc();
        start = 0;
    endtask

    task automatic pulse_tick();
        tick = 1;
        cyc();
        tick = 0;
    endtask

    function automatic vec_t mk(input logic ld, input logic [3:0] st, input logic [3:0] so,
                                input logic sr, input logic pa, input logic tk,
                                input logic [7:0] dg, input logic rn, input logic ex,
                                input logic ce);
        vec_t v;
        v.load = ld; v.st = st; v.so = so; v.start = sr; v.pause = pa; v.tick = tk;
        v.e_digits = dg; v.e_run = rn; v.e_exp = ex; v.e_ce = ce;
        return v;
    endfunction

    initial begin
        idle_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        check("reset_digits", {t0, o0}, 8'h00);
        check("reset_run", run0, 1'b0);
        check("reset_exp", exp0, 1'b0);
        check("reset_ce", ce0, 1'b0);
        check("reset_ar_digits", {t1, o1}, 8'h00);

        //        ld  st     so     sr pa tk  digits  run exp ce
        vecs.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 8'h00, 0, 0, 0)); // start in IDLE ignored
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 8'h00, 0, 0, 0)); // tick in IDLE ignored
        vecs.push_back(mk(1, 4'hA, 4'hF, 0, 0, 0, 8'h99, 0, 0, 0)); // clamp both digits
        vecs.push_back(mk(1, 4'h0, 4'h3, 0, 0, 0, 8'h03, 0, 0, 0)); // recapture in ARMED
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 8'h03, 0, 0, 0)); // tick in ARMED ignored
        vecs.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 8'h03, 1, 0, 0)); // start -> RUN
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 8'h03, 1, 0, 1)); // lag-cycle tick ignored
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 8'h02, 1, 0, 1)); // decrement
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 1, 1, 8'h02, 1, 0, 0)); // paused tick ignored
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 8'h02, 1, 0, 1)); // enable still low
        vecs.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 8'h02, 1, 0, 1)); // start in RUN ignored
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 8'h01, 1, 0, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 8'h00, 0, 1, 1)); // expiry
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 8'h00, 0, 0, 0)); // tick in DONE ignored
        vecs.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 8'h00, 0, 0, 0)); // start in DONE ignored
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 8'h00, 0, 0, 0)); // load 00
        vecs.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 8'h00, 0, 1, 0)); // start at 00 expires
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 8'h00, 0, 0, 0)); // single pulse
        vecs.push_back(mk(1, 4'hC, 4'h3, 0, 0, 0, 8'h93, 0, 0, 0)); // clamp tens only
        vecs.push_back(mk(1, 4'h1, 4'h0, 1, 0, 0, 8'h10, 0, 0, 0)); // load beats start
        vecs.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 8'h10, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 8'h10, 1, 0, 1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 1, 8'h09, 1, 0, 1)); // borrow 10 -> 09
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 8'h09, 1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 8'h09, 1, 0, 1));
        vecs.push_back(mk(1, 4'h0, 4'h7, 0, 0, 1, 8'h07, 0, 0, 1)); // load beats tick in RUN
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 8'h07, 0, 0, 0));

        foreach (vecs[i]) begin
            load = vecs[i].load; start_tens = vecs[i].st; start_ones = vecs[i].so;
            start = vecs[i].start; pause = vecs[i].pause; tick = vecs[i].tick;
            cyc();
            check($sformatf("vec%0d_digits", i), {t0, o0}, vecs[i].e_digits);
            check($sformatf("vec%0d_run", i), run0, vecs[i].e_run);
            check($sformatf("vec%0d_exp", i), exp0, vecs[i].e_exp);
            check($sformatf("vec%0d_ce", i), ce0, vecs[i].e_ce);
        end
        idle_inputs();

        // Full 30 -> 00 countdown, ticks spaced five cycles apart.
        do_reset();
        do_load(4'd3, 4'd0);
        pulse_start();
        cyc();
        cyc();
        for (int v = 29; v >= 0; v--) begin
            pulse_tick();
            check($sformatf("cd%0d_digits", v), {t0, o0}, {4'(v / 10), 4'(v % 10)});
            check($sformatf("cd%0d_exp", v), exp0, (v == 0));
            check($sformatf("cd%0d_run", v), run0, (v != 0));
            for (int k = 0; k < 4; k++) begin
                cyc();
                if (k == 0) check($sformatf("cd%0d_nopulse", v), exp0, 1'b0);
            end
        end
        check("cd_end_ce", ce0, 1'b0);
        check("cd_end_digits", {t0, o0}, 8'h00);

        // Pause freezes the count and drops the enable.
        do_reset();
        do_load(4'd0, 4'd5);
        pulse_start();
        cyc();
        pause = 1;
        for (int k = 0; k < 20; k++) begin
            tick = k[0];
            cyc();
            check($sformatf("pause%0d_digits", k), {t0, o0}, 8'h05);
            check($sformatf("pause%0d_ce", k), ce0, 1'b0);
        end
        tick = 0;
        pause = 0;
        cyc();
        check("resume_ce", ce0, 1'b1);
        pulse_tick();
        check("resume_digits", {t0, o0}, 8'h04);

        // Auto-reload instance reloads and keeps running; the other stops.
        do_reset();
        do_load(4'd0, 4'd2);
        pulse_start();
        cyc();
        pulse_tick();
        check("ar_first_tick", {t1, o1}, 8'h01);
        pulse_tick();
        check("ar_reload_digits", {t1, o1}, 8'h02);
        check("ar_reload_exp", exp1, 1'b1);
        check("ar_reload_run", run1, 1'b1);
        check("nr_expire_digits", {t0, o0}, 8'h00);
        check("nr_expire_run", run0, 1'b0);
        cyc();
        check("ar_after_exp", exp1, 1'b0);
        check("ar_after_run", run1, 1'b1);

        // Reset mid-countdown wins over a coincident load and tick.
        do_reset();
        do_load(4'd1, 4'd5);
        pulse_start();
        cyc();
        rst = 1; tick = 1; load = 1; start_tens = 4'd0; start_ones = 4'd7;
        cyc();
        check("abort_digits", {t0, o0}, 8'h00);
        check("abort_exp", exp0, 1'b0);
        check("abort_run", run0, 1'b0);
        rst = 0; tick = 0; load = 0;
        pulse_start();
        check("abort_start_run", run0, 1'b0);
        cyc();
        tick = 1;
        cyc();
        tick = 0;
        check("abort_tick_digits", {t0, o0}, 8'h00);
        check("abort_ce", ce0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 Parameter AUTO_RELOAD, default 0; when 1, expiry reloads the last loaded value and counting continues.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 load  input  1  one-cycle request to capture start_tens/start_ones.
REQ-005 start_tens  input  4  BCD tens digit of the start value.
REQ-006 start_ones  input  4  BCD ones digit of the start value.
REQ-007 start  input  1  one-cycle request to begin or resume the countdown.
REQ-008 pause  input  1  level; while high in RUN, counting is frozen.
REQ-009 tick  input  1  one-cycle pulse from the upstream tick counter (its timeout output).
REQ-010 count_en  output  1  enable to the upstream tick counter.
REQ-011 tens  output  4  current BCD tens digit.
REQ-012 ones  output  4  current BCD ones digit.
REQ-013 running  output  1  high while state is RUN.
REQ-014 expired  output  1  one-cycle pulse when the count reaches 00.

Function
REQ-015 States: IDLE, ARMED, RUN, DONE; all outputs registered.
REQ-016 IDLE: load -> ARMED; start and tick ignored.
REQ-017 ARMED: start -> RUN; load -> recapture, stay ARMED; tick ignored.
REQ-018 RUN: tick with pause=0 -> decrement one step; load -> recapture, go ARMED.
REQ-019 DONE: load -> ARMED; start and tick ignored; digits hold 00.
REQ-020 Load capture: digits >9 clamp to 9 independently (e.g. 4'hC,4'h3 -> 9,3); clamped value also stored as reload value.
REQ-021 Decrement: ones>0 -> ones-1; ones=0 -> ones=9 and tens-1; never below 00.
REQ-022 Tick at 01 in RUN -> next cycle digits 00, expired=1 for exactly that cycle, state DONE (AUTO_RELOAD=0).
REQ-023 AUTO_RELOAD=1: tick at 01 -> next cycle digits = reload value, expired=1 for one cycle, state stays RUN.
REQ-024 Start in ARMED with value 00 -> next cycle expired=1, state DONE (AUTO_RELOAD=0), or no-expire stay-ARMED never; with AUTO_RELOAD=1 same cycle treatment as REQ-022 (state DONE, since reload of 00 is meaningless).
REQ-025 count_en = 1 iff state RUN and pause=0; registered, one-cycle lag from pause/state change.
REQ-026 Ticks arriving while count_en low (including the lag cycle) are ignored.
REQ-027 Priority in one cycle: rst > load > start > tick.
REQ-028 pause has no effect outside RUN; start while RUN is ignored.
REQ-029 expired never asserts on two consecutive cycles.

Reset
REQ-030 rst=1 on a clock edge -> state IDLE, tens=0, ones=0, reload value 00, count_en=0, running=0, expired=0.
REQ-031 rst mid-countdown aborts immediately; no expired pulse; load on the same cycle as rst is ignored.
REQ-032 After rst release, block stays in IDLE until load.

Verification
REQ-033 load 3,0; start; 30 ticks spaced 5 cycles -> digits 29,28,...,00; borrow 20->19 correct; expired single pulse with 00; running falls; count_en 0.
REQ-034 load 0,5; start; pause=1 for 20 cycles with ticks injected -> digits hold 05, count_en 0; pause=0 -> resumes 04.
REQ-035 load 4'hA,4'hF -> tens=9, ones=9 after capture.
REQ-036 In RUN at 12, load 0,7 and tick same cycle -> digits 07, state ARMED, running=0.
REQ-037 AUTO_RELOAD=1, load 0,2; start; 2 ticks -> 01, then 02 with expired pulse, running stays 1.
REQ-038 In RUN at 15, assert rst for one cycle with tick -> digits 00, IDLE, no expired; subsequent start ignored.
